// File: rtl/side_request_conditioner_pkg.sv
// Shared types and defaults for the side-road request conditioner.
package side_request_conditioner_pkg;

    // Request FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2,
        HOLD    = 2'd3
    } reqState_t;

    localparam int unsigned DEB_TICKS_DEF  = 20;
    localparam int unsigned HOLD_TICKS_DEF = 3;
    localparam int unsigned CNT_W_DEF      = 8;

    // True while the side road holds green for queued vehicles
    function automatic logic isServed(reqState_t st);
        return (st == SERVING) || (st == HOLD);
    endfunction

endpackage

// File: rtl/side_request_conditioner_sync_debounce.sv
// Synchroniser plus tick-based debounce filter; emits the clean level and its edges.
module side_request_conditioner_sync_debounce
    import side_request_conditioner_pkg::*;
#(
    parameter int unsigned DEB_TICKS = DEB_TICKS_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic TICK,
    input  logic SENSE_RAW,
    output logic PRESENCE,
    output logic ARR,
    output logic DEP
);

    localparam int unsigned DEB_W = $clog2(DEB_TICKS + 1);

    logic             syncA;
    logic             syncB;
    logic [DEB_W-1:0] debCnt;

    // Two-flop synchroniser for the asynchronous sensor
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            syncA <= 1'b0;
            syncB <= 1'b0;
        end else begin
            syncA <= SENSE_RAW;
            syncB <= syncA;
        end
    end

    // Level flips only after DEB_TICKS consecutive differing samples; edges pulse with the flip
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            debCnt   <= '0;
            PRESENCE <= 1'b0;
            ARR      <= 1'b0;
            DEP      <= 1'b0;
        end else begin
            ARR <= 1'b0;
            DEP <= 1'b0;
            if (TICK) begin
                if (syncB == PRESENCE) begin
                    debCnt <= '0;
                end else if (debCnt == DEB_W'(DEB_TICKS - 1)) begin
                    debCnt   <= '0;
                    PRESENCE <= syncB;
                    ARR      <= syncB;
                    DEP      <= ~syncB;
                end else begin
                    debCnt <= debCnt + DEB_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/side_request_conditioner.sv
// Side-road request conditioner: debounced presence, vehicle queue count and request FSM.
module side_request_conditioner
    import side_request_conditioner_pkg::*;
#(
    parameter int unsigned DEB_TICKS  = DEB_TICKS_DEF,
    parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             TICK,
    input  logic             SENSE_RAW,
    input  logic             F_GREEN,
    output logic             S,
    output logic             PRESENCE,
    output logic [CNT_W-1:0] REQ_CNT
);

    localparam int unsigned      HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    reqState_t         state;
    reqState_t         stateNext;
    logic [HOLD_W-1:0] holdCnt;
    logic [HOLD_W-1:0] holdNext;
    logic              arr;
    logic              dep;
    logic              fgPrev;
    logic              fgFall;

    side_request_conditioner_sync_debounce #(
        .DEB_TICKS (DEB_TICKS)
    ) u_syncDebounce (
        .CLK       (CLK),
        .RESET     (RESET),
        .TICK      (TICK),
        .SENSE_RAW (SENSE_RAW),
        .PRESENCE  (PRESENCE),
        .ARR       (arr),
        .DEP       (dep)
    );

    assign fgFall = fgPrev & ~F_GREEN;

    // Green-lamp history for edge detection at CLK rate
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fgPrev <= 1'b0;
        end else begin
            fgPrev <= F_GREEN;
        end
    end

    // Saturating queue count; departures only count while the side road is served
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            REQ_CNT <= '0;
        end else if (arr) begin
            if (REQ_CNT != CNT_MAX) begin
                REQ_CNT <= REQ_CNT + CNT_W'(1);
            end
        end else if (dep && isServed(state) && (REQ_CNT != '0)) begin
            REQ_CNT <= REQ_CNT - CNT_W'(1);
        end
    end

    // State, hold timer and registered request decoded from the next state
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            holdCnt <= '0;
            S       <= 1'b0;
        end else begin
            state   <= stateNext;
            holdCnt <= holdNext;
            S       <= (stateNext != IDLE);
        end
    end

    // Next-state logic; green fall beats arrival beats hold expiry
    always_comb begin
        stateNext = state;
        holdNext  = holdCnt;
        unique case (state)
            IDLE: begin
                if (arr) begin
                    stateNext = PENDING;
                end
            end
            PENDING: begin
                // Level test covers both a fresh rise and green already being on
                if (F_GREEN) begin
                    stateNext = SERVING;
                end
            end
            SERVING: begin
                if (fgFall) begin
                    stateNext = (REQ_CNT != '0) ? PENDING : IDLE;
                end else if ((REQ_CNT == '0) && !PRESENCE) begin
                    stateNext = HOLD;
                    holdNext  = HOLD_W'(HOLD_TICKS);
                end
            end
            HOLD: begin
                if (fgFall) begin
                    stateNext = (REQ_CNT != '0) ? PENDING : IDLE;
                end else if (arr) begin
                    stateNext = SERVING;
                end else if (TICK) begin
                    if (holdCnt <= HOLD_W'(1)) begin
                        stateNext = IDLE;
                        holdNext  = '0;
                    end else begin
                        holdNext = holdCnt - HOLD_W'(1);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_side_request_conditioner.sv
// Randomised scoreboard bench: two conditioner instances against a tick-level reference model.
module tb_side_request_conditioner;

    localparam int CNT_MAX = 3;
    localparam int M_IDLE  = 0;
    localparam int M_PEND  = 1;
    localparam int M_SERV  = 2;
    localparam int M_HOLD  = 3;

    typedef struct packed {
        logic       sA;
        logic       pA;
        logic [1:0] cA;
        logic       sB;
        logic       pB;
        logic [1:0] cB;
    } exp_t;

    logic       CLK;
    logic       RESET;
    logic       TICK;
    logic       SENSE_RAW;
    logic       F_GREEN;
    logic       sA, pA, sB, pB;
    logic [1:0] cA, cB;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    event sampleEv;

    int mState[2];
    int mPres[2];
    int mDeb[2];
    int mCnt[2];
    int mHold[2];
    bit mGPrev;

    // Instance A: nominal debounce and hold; instance B: short debounce, long hold
    side_request_conditioner #(.DEB_TICKS(20), .HOLD_TICKS(3), .CNT_W(2)) dutA (
        .CLK(CLK), .RESET(RESET), .TICK(TICK), .SENSE_RAW(SENSE_RAW), .F_GREEN(F_GREEN),
        .S(sA), .PRESENCE(pA), .REQ_CNT(cA)
    );

    side_request_conditioner #(.DEB_TICKS(4), .HOLD_TICKS(6), .CNT_W(2)) dutB (
        .CLK(CLK), .RESET(RESET), .TICK(TICK), .SENSE_RAW(SENSE_RAW), .F_GREEN(F_GREEN),
        .S(sB), .PRESENCE(pB), .REQ_CNT(cB)
    );

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    function automatic int debOf(input int k);
        return (k == 0) ? 20 : 4;
    endfunction

    function automatic int holdOf(input int k);
        return (k == 0) ? 3 : 6;
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            mState[k] = M_IDLE;
            mPres[k]  = 0;
            mDeb[k]   = 0;
            mCnt[k]   = 0;
            mHold[k]  = 0;
        end
        mGPrev = F_GREEN;
    endfunction

    // Apply level-triggered moves until nothing changes
    function automatic void settle(input int k, input bit g);
        for (int i = 0; i < 4; i++) begin
            if (mState[k] == M_PEND && g) begin
                mState[k] = M_SERV;
            end else if (mState[k] == M_SERV && mCnt[k] == 0 && mPres[k] == 0) begin
                mState[k] = M_HOLD;
                mHold[k]  = holdOf(k);
            end
        end
    endfunction

    // One tick period: green edge first, then the tick, then the resulting arrival/departure
    function automatic void modelPeriod(input bit r, input bit g);
        for (int k = 0; k < 2; k++) begin
            bit arrv;
            bit depv;
            int oldCnt;
            int oldState;
            if (mGPrev && !g && (mState[k] == M_SERV || mState[k] == M_HOLD))
                mState[k] = (mCnt[k] > 0) ? M_PEND : M_IDLE;
            settle(k, g);
            if (mState[k] == M_HOLD) begin
                mHold[k] = mHold[k] - 1;
                if (mHold[k] <= 0) mState[k] = M_IDLE;
            end
            arrv = 1'b0;
            depv = 1'b0;
            if (int'(r) != mPres[k]) begin
                mDeb[k] = mDeb[k] + 1;
                if (mDeb[k] == debOf(k)) begin
                    mPres[k] = int'(r);
                    mDeb[k]  = 0;
                    arrv     = r;
                    depv     = !r;
                end
            end else begin
                mDeb[k] = 0;
            end
            oldCnt   = mCnt[k];
            oldState = mState[k];
            if (arrv && mState[k] == M_IDLE) begin
                mState[k] = M_PEND;
            end else if (arrv && mState[k] == M_HOLD) begin
                mState[k] = M_SERV;
            end else if (!arrv && mState[k] == M_SERV && oldCnt == 0 && mPres[k] == 0) begin
                mState[k] = M_HOLD;
                mHold[k]  = holdOf(k);
            end
            if (arrv && mCnt[k] < CNT_MAX) mCnt[k] = mCnt[k] + 1;
            if (depv && (oldState == M_SERV || oldState == M_HOLD) && mCnt[k] > 0)
                mCnt[k] = mCnt[k] - 1;
            settle(k, g);
        end
        mGPrev = g;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.sA = (mState[0] != M_IDLE);
        e.pA = 1'(mPres[0]);
        e.cA = 2'(mCnt[0]);
        e.sB = (mState[1] != M_IDLE);
        e.pB = 1'(mPres[1]);
        e.cB = 2'(mCnt[1]);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the driver marks a sample point
    initial begin : monitor
        exp_t e;
        forever begin
            @(sampleEv);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
            end else begin
                e = expQ.pop_front();
                check("S_A",        int'(sA), int'(e.sA));
                check("PRESENCE_A", int'(pA), int'(e.pA));
                check("REQ_CNT_A",  int'(cA), int'(e.cA));
                check("S_B",        int'(sB), int'(e.sB));
                check("PRESENCE_B", int'(pB), int'(e.pB));
                check("REQ_CNT_B",  int'(cB), int'(e.cB));
            end
        end
    end

    // Eight-cycle period: inputs change, TICK in the fourth cycle, sample in the last
    task automatic period(input bit r, input bit g);
        @(negedge CLK);
        SENSE_RAW = r;
        F_GREEN   = g;
        TICK      = 1'b0;
        repeat (2) @(negedge CLK);
        TICK = 1'b1;
        @(negedge CLK);
        TICK = 1'b0;
        repeat (4) @(negedge CLK);
        modelPeriod(r, g);
        expQ.push_back(snap());
        -> sampleEv;
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock edge
    task automatic doReset();
        @(negedge CLK);
        #1 RESET = 1'b1;
        #1;
        modelReset();
        expQ.push_back(snap());
        -> sampleEv;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit rr;
        bit gg;
        int len;
        RESET     = 1'b1;
        TICK      = 1'b0;
        SENSE_RAW = 1'b1;
        F_GREEN   = 1'b0;
        modelReset();
        repeat (3) @(negedge CLK);
        expQ.push_back(snap());
        -> sampleEv;
        @(negedge CLK);
        RESET = 1'b0;

        // Request after reset: presence on tick 20, count 1, S raised
        repeat (25) period(1'b1, 1'b0);
        // Service: green, vehicle leaves, gap hold then IDLE
        repeat (3)  period(1'b1, 1'b1);
        repeat (26) period(1'b0, 1'b1);
        repeat (2)  period(1'b0, 1'b0);
        // Glitch of 19 ticks on instance A
        repeat (19) period(1'b1, 1'b0);
        repeat (5)  period(1'b0, 1'b0);
        // Two arrivals, green rises and ends early
        for (int v = 0; v < 2; v++) begin
            repeat (21) period(1'b1, 1'b0);
            repeat (21) period(1'b0, 1'b0);
        end
        repeat (2) period(1'b0, 1'b1);
        repeat (2) period(1'b0, 1'b0);
        // Three more arrivals saturate the 2-bit count
        for (int v = 0; v < 3; v++) begin
            repeat (21) period(1'b1, 1'b0);
            repeat (21) period(1'b0, 1'b0);
        end
        doReset();
        // Arrival during the gap hold of instance B
        repeat (5) period(1'b1, 1'b0);
        repeat (2) period(1'b1, 1'b1);
        repeat (5) period(1'b0, 1'b1);
        repeat (5) period(1'b1, 1'b1);
        repeat (8) period(1'b0, 1'b1);
        repeat (2) period(1'b0, 1'b0);

        // Random segments of long presses and short glitches with random green toggling
        rr = 1'b0;
        gg = 1'b0;
        for (int seg = 0; seg < 60; seg++) begin
            rr  = ~rr;
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(18, 30))
                                              : int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) == 0) gg = ~gg;
                period(rr, gg);
            end
            if ($urandom_range(0, 29) == 0) doReset();
        end

        repeat (2) @(negedge CLK);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
